// File: rtl/sudoku_pkg.sv
// Shared types and constants for the Sudoku board controller.
package sudoku_pkg;

   localparam int unsigned CELLS   = 81;
   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned GRID    = 9;
   localparam int unsigned IDX_W   = 7;
   localparam int unsigned BOARD_W = CELLS * DIGIT_W;

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StLoadDrain,
      StClear
   } state_e;

   // Linear cell index, row-major.
   function automatic logic [IDX_W-1:0] cell_idx(input logic [3:0] row, input logic [3:0] col);
      return ({3'b000, row} * 7'd9) + {3'b000, col};
   endfunction

endpackage

// File: rtl/sudoku_wr_check.sv
// Legality check for a single user cell write: range, digit value and given-cell protection.
module sudoku_wr_check
   import sudoku_pkg::*;
(
   input  logic [3:0]       row_i,
   input  logic [3:0]       col_i,
   input  logic [3:0]       val_i,
   input  logic [CELLS-1:0] board_blank_i,
   output logic             legal_o,
   output logic [IDX_W-1:0] idx_o
);

   logic in_range;

   // Index is forced to 0 when out of range so the given-cell lookup never indexes past the board.
   always_comb begin
      in_range = (row_i < 4'd9) && (col_i < 4'd9) && (val_i <= 4'd9);
      idx_o    = in_range ? cell_idx(row_i, col_i) : '0;
      legal_o  = in_range && board_blank_i[idx_o];
   end

endmodule

// File: rtl/sudoku_board_ctrl.sv
// Sudoku board state owner: schedules puzzle load, clear and user writes into vertical blanking.
module sudoku_board_ctrl
   import sudoku_pkg::*;
#(
   parameter int unsigned PUZZLE_W   = 3,
   parameter int unsigned ROM_ADDR_W = PUZZLE_W + 7
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  in_blank_i,
   input  logic                  load_req_i,
   input  logic [PUZZLE_W-1:0]   puzzle_id_i,
   input  logic                  clr_req_i,
   input  logic                  wr_valid_i,
   output logic                  wr_ready_o,
   input  logic [3:0]            wr_row_i,
   input  logic [3:0]            wr_col_i,
   input  logic [3:0]            wr_val_i,
   output logic                  wr_err_o,
   output logic [ROM_ADDR_W-1:0] rom_addr_o,
   input  logic [DIGIT_W-1:0]    rom_data_i,
   output logic [BOARD_W-1:0]    board_o,
   output logic [CELLS-1:0]      board_blank_o,
   output logic                  busy_o,
   output logic                  load_done_o,
   output logic [6:0]            filled_o
);

   state_e               state_q;
   logic                 load_pend_q, clr_pend_q;
   logic [PUZZLE_W-1:0]  pend_pid_q, cur_pid_q;
   logic [IDX_W-1:0]     cnt_q;
   logic                 rd_valid_q;
   logic [IDX_W-1:0]     rd_cell_q;
   logic [BOARD_W-1:0]   board_q;
   logic [CELLS-1:0]     blank_q;
   logic [6:0]           filled_q;
   logic                 wr_err_q, load_done_q;

   logic                 wr_legal, wr_accept;
   logic [IDX_W-1:0]     wr_idx;
   logic                 rd_old_nz, rd_new_nz, wr_old_nz, wr_new_nz;
   logic [6:0]           clr_nz_cnt;

   sudoku_wr_check u_wr_check (
      .row_i         (wr_row_i),
      .col_i         (wr_col_i),
      .val_i         (wr_val_i),
      .board_blank_i (blank_q),
      .legal_o       (wr_legal),
      .idx_o         (wr_idx)
   );

   // Handshake, filled-count deltas and number of user digits a clear would remove.
   always_comb begin
      wr_ready_o = !rst_i && (state_q == StIdle) && in_blank_i && !load_pend_q && !clr_pend_q;
      wr_accept  = wr_valid_i && wr_ready_o;
      rd_old_nz  = |board_q[{rd_cell_q, 2'b00} +: DIGIT_W];
      rd_new_nz  = |rom_data_i;
      wr_old_nz  = |board_q[{wr_idx, 2'b00} +: DIGIT_W];
      wr_new_nz  = |wr_val_i;
      clr_nz_cnt = '0;
      for (int i = 0; i < CELLS; i++) begin
         if (blank_q[i] && (board_q[i*DIGIT_W +: DIGIT_W] != '0)) clr_nz_cnt = clr_nz_cnt + 7'd1;
      end
   end

   // Controller FSM with all board state and registered status outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         load_pend_q <= 1'b0;
         clr_pend_q  <= 1'b0;
         pend_pid_q  <= '0;
         cur_pid_q   <= '0;
         cnt_q       <= '0;
         rd_valid_q  <= 1'b0;
         rd_cell_q   <= '0;
         board_q     <= '0;
         blank_q     <= '0;
         filled_q    <= '0;
         wr_err_q    <= 1'b0;
         load_done_q <= 1'b0;
      end else begin
         wr_err_q    <= 1'b0;
         load_done_q <= 1'b0;
         rd_valid_q  <= 1'b0;

         // ROM data for the previously issued cell commits even if blanking just ended.
         if (rd_valid_q) begin
            board_q[{rd_cell_q, 2'b00} +: DIGIT_W] <= rom_data_i;
            blank_q[rd_cell_q] <= !rd_new_nz;
            filled_q <= filled_q + 7'(rd_new_nz) - 7'(rd_old_nz);
         end

         unique case (state_q)
            StIdle: begin
               if (in_blank_i && load_pend_q) begin
                  state_q     <= StLoad;
                  load_pend_q <= 1'b0;
                  cur_pid_q   <= pend_pid_q;
                  cnt_q       <= '0;
               end else if (in_blank_i && clr_pend_q) begin
                  state_q <= StClear;
               end else if (wr_accept) begin
                  if (wr_legal) begin
                     board_q[{wr_idx, 2'b00} +: DIGIT_W] <= wr_val_i;
                     filled_q <= filled_q + 7'(wr_new_nz) - 7'(wr_old_nz);
                  end else begin
                     wr_err_q <= 1'b1;
                  end
               end
            end
            StLoad: begin
               if (in_blank_i) begin
                  rd_valid_q <= 1'b1;
                  rd_cell_q  <= cnt_q;
                  if (cnt_q == IDX_W'(CELLS - 1)) state_q <= StLoadDrain;
                  else                           cnt_q   <= cnt_q + 7'd1;
               end
            end
            StLoadDrain: begin
               load_done_q <= 1'b1;
               state_q     <= StIdle;
            end
            StClear: begin
               if (in_blank_i) begin
                  for (int i = 0; i < CELLS; i++) begin
                     if (blank_q[i]) board_q[i*DIGIT_W +: DIGIT_W] <= '0;
                  end
                  filled_q   <= filled_q - clr_nz_cnt;
                  clr_pend_q <= 1'b0;
                  state_q    <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase

         // New requests win over same-cycle pend clears so nothing is lost.
         if (load_req_i) begin
            load_pend_q <= 1'b1;
            pend_pid_q  <= puzzle_id_i;
         end
         if (clr_req_i) clr_pend_q <= 1'b1;
      end
   end

   assign rom_addr_o    = {cur_pid_q, cnt_q};
   assign board_o       = board_q;
   assign board_blank_o = blank_q;
   assign filled_o      = filled_q;
   assign wr_err_o      = wr_err_q;
   assign load_done_o   = load_done_q;
   assign busy_o        = load_pend_q || clr_pend_q || (state_q != StIdle);

endmodule

// File: tb/tb_sudoku_board_ctrl.sv
// Directed bench for sudoku_board_ctrl with a synchronous ROM model.
module tb_sudoku_board_ctrl;

   logic         clk = 1'b0;
   logic         rst, in_blank, load_req, clr_req, wr_valid;
   logic [2:0]   puzzle_id;
   logic [3:0]   wr_row, wr_col, wr_val, rom_data;
   logic         wr_ready, wr_err, busy, load_done;
   logic [9:0]   rom_addr;
   logic [323:0] board;
   logic [80:0]  board_blank;
   logic [6:0]   filled;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sudoku_board_ctrl dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .in_blank_i    (in_blank),
      .load_req_i    (load_req),
      .puzzle_id_i   (puzzle_id),
      .clr_req_i     (clr_req),
      .wr_valid_i    (wr_valid),
      .wr_ready_o    (wr_ready),
      .wr_row_i      (wr_row),
      .wr_col_i      (wr_col),
      .wr_val_i      (wr_val),
      .wr_err_o      (wr_err),
      .rom_addr_o    (rom_addr),
      .rom_data_i    (rom_data),
      .board_o       (board),
      .board_blank_o (board_blank),
      .busy_o        (busy),
      .load_done_o   (load_done),
      .filled_o      (filled)
   );

   // Puzzle contents: puzzle 2 has cell 0 = 7; cells 79 and 80 are always empty.
   function automatic logic [3:0] rom_val(input int pid, input int c);
      if (pid == 2 && c == 0) return 4'd7;
      if (c >= 79) return 4'd0;
      if (((c * 5 + pid) % 3) == 0) return 4'd0;
      return 4'((c + pid) % 9 + 1);
   endfunction

   always @(posedge clk) rom_data <= rom_val(int'(rom_addr[9:7]), int'(rom_addr[6:0]));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_wide(input string name, input logic [323:0] act, input logic [323:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model(input int pid, input int ncells, output logic [323:0] b,
                        output logic [80:0] bl, output int nz);
      logic [3:0] v;
      b = '0; bl = '0; nz = 0;
      for (int c = 0; c < ncells; c++) begin
         v = rom_val(pid, c);
         b[c*4 +: 4] = v;
         bl[c] = (v == 4'd0);
         if (v != 4'd0) nz++;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_load_done(output int n);
      n = 0;
      for (int i = 1; i <= 300; i++) begin
         step();
         if (load_done === 1'b1) begin
            n = i;
            break;
         end
      end
      if (n == 0) check("load_done timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idle();
      int seen = 0;
      for (int i = 0; i < 300; i++) begin
         if (busy === 1'b0) begin
            seen = 1;
            break;
         end
         step();
      end
      if (seen == 0) check("busy timeout", 32'd1, 32'd0);
   endtask

   task automatic pulse_load(input logic [2:0] pid, input logic with_clr);
      puzzle_id = pid;
      load_req  = 1'b1;
      clr_req   = with_clr;
      step();
      load_req  = 1'b0;
      clr_req   = 1'b0;
   endtask

   typedef struct {
      logic [3:0] row, col, val;
      logic       exp_err;
      int         idx;
      logic [3:0] exp_cell;
      int         fdelta;
   } wr_vec_t;

   wr_vec_t vecs[8];

   initial begin
      logic [323:0] exp_b;
      logic [80:0]  exp_bl;
      int           nz, nz41, n, fexp;
      logic [9:0]   addr_hold;
      int           addr_moved;

      vecs[0] = '{4'd0, 4'd0, 4'd3,  1'b1, 0,  4'd7, 0};
      vecs[1] = '{4'd8, 4'd8, 4'd10, 1'b1, 80, 4'd0, 0};
      vecs[2] = '{4'd9, 4'd0, 4'd1,  1'b1, 0,  4'd7, 0};
      vecs[3] = '{4'd0, 4'd9, 4'd1,  1'b1, 0,  4'd7, 0};
      vecs[4] = '{4'd8, 4'd8, 4'd4,  1'b0, 80, 4'd4, 1};
      vecs[5] = '{4'd8, 4'd7, 4'd9,  1'b0, 79, 4'd9, 1};
      vecs[6] = '{4'd8, 4'd8, 4'd0,  1'b0, 80, 4'd0, -1};
      vecs[7] = '{4'd8, 4'd8, 4'd4,  1'b0, 80, 4'd4, 1};

      rst = 1'b1; in_blank = 1'b1; load_req = 1'b0; clr_req = 1'b0; wr_valid = 1'b0;
      puzzle_id = '0; wr_row = '0; wr_col = '0; wr_val = '0;
      repeat (3) step();
      check_wide("reset board", board, '0);
      check("reset blank", 32'(board_blank == '0), 32'd1);
      check("reset filled", 32'(filled), 32'd0);
      check("reset wr_ready", 32'(wr_ready), 32'd0);
      check("reset wr_err", 32'(wr_err), 32'd0);
      check("reset load_done", 32'(load_done), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      check("reset rom_addr", 32'(rom_addr), 32'd0);
      rst = 1'b0;
      step();

      // After reset every cell is a given, so the first write is refused.
      wr_row = 4'd0; wr_col = 4'd0; wr_val = 4'd5; wr_valid = 1'b1;
      #1;
      check("post-reset wr_ready", 32'(wr_ready), 32'd1);
      step();
      wr_valid = 1'b0;
      check("post-reset wr_err", 32'(wr_err), 32'd1);
      check("post-reset cell0", 32'(board[3:0]), 32'd0);

      // Reset in the middle of a load discards the partial board.
      pulse_load(3'd5, 1'b0);
      repeat (12) step();
      check("mid-load busy", 32'(busy), 32'd1);
      rst = 1'b1;
      step();
      check_wide("mid-load reset board", board, '0);
      check("mid-load reset filled", 32'(filled), 32'd0);
      check("mid-load reset busy", 32'(busy), 32'd0);
      check("mid-load reset rom_addr", 32'(rom_addr), 32'd0);
      rst = 1'b0;
      step();

      // Blanking ends after 41 issued addresses: cells 0..40 present, rom_addr frozen.
      pulse_load(3'd5, 1'b0);
      step();
      repeat (41) step();
      in_blank = 1'b0;
      step();
      addr_hold = rom_addr;
      addr_moved = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (rom_addr !== addr_hold) addr_moved = 1;
      end
      check("pause rom_addr", 32'(addr_hold), 32'({3'd5, 7'd41}));
      check("pause rom_addr held", 32'(addr_moved), 32'd0);
      model(5, 41, exp_b, exp_bl, nz41);
      check("pause filled", 32'(filled), 32'(nz41));
      check_wide("pause cells 0..40", {164'd0, board[163:0]}, {164'd0, exp_b[163:0]});
      check_wide("pause cells 41..80", {164'd0, board[323:164]}, '0);
      in_blank = 1'b1;
      wait_load_done(n);
      model(5, 81, exp_b, exp_bl, nz);
      check_wide("p5 board", board, exp_b);
      check("p5 blank", 32'(board_blank == exp_bl), 32'd1);
      check("p5 filled", 32'(filled), 32'(nz));

      // Uninterrupted load: 1 pend cycle + 81 issue cycles + 1 drain cycle.
      pulse_load(3'd2, 1'b0);
      wait_load_done(n);
      check("load_done latency", 32'(n), 32'd83);
      check("p2 cell0", 32'(board[3:0]), 32'd7);
      check("p2 blank0", 32'(board_blank[0]), 32'd0);
      check("p2 blank80", 32'(board_blank[80]), 32'd1);
      model(2, 81, exp_b, exp_bl, nz);
      check_wide("p2 board", board, exp_b);
      check("p2 filled", 32'(filled), 32'(nz));
      step();
      check("load_done pulse", 32'(load_done), 32'd0);

      fexp = nz;
      foreach (vecs[k]) begin
         wr_row = vecs[k].row; wr_col = vecs[k].col; wr_val = vecs[k].val; wr_valid = 1'b1;
         #1;
         check($sformatf("vec%0d wr_ready", k), 32'(wr_ready), 32'd1);
         step();
         wr_valid = 1'b0;
         fexp = fexp + vecs[k].fdelta;
         check($sformatf("vec%0d wr_err", k), 32'(wr_err), 32'(vecs[k].exp_err));
         check($sformatf("vec%0d cell", k), 32'(board[vecs[k].idx*4 +: 4]), 32'(vecs[k].exp_cell));
         check($sformatf("vec%0d filled", k), 32'(filled), 32'(fexp));
      end
      step();
      check("wr_err pulse", 32'(wr_err), 32'd0);

      // Writes are held off outside blanking.
      in_blank = 1'b0;
      wr_row = 4'd8; wr_col = 4'd8; wr_val = 4'd1; wr_valid = 1'b1;
      #1;
      check("active wr_ready", 32'(wr_ready), 32'd0);
      step();
      wr_valid = 1'b0;
      check("active cell80", 32'(board[323:320]), 32'd4);
      in_blank = 1'b1;
      step();

      // Clear removes user digits in cells 79 and 80 only.
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      check("clear busy", 32'(busy), 32'd1);
      wait_idle();
      check("clear cell79", 32'(board[319:316]), 32'd0);
      check("clear cell80", 32'(board[323:320]), 32'd0);
      check("clear cell0", 32'(board[3:0]), 32'd7);
      check("clear filled", 32'(filled), 32'(fexp - 2));
      check_wide("clear board", board, exp_b);

      // Load and clear requested together: load completes first, clear still pending.
      wr_row = 4'd8; wr_col = 4'd8; wr_val = 4'd6; wr_valid = 1'b1;
      step();
      wr_valid = 1'b0;
      pulse_load(3'd3, 1'b1);
      step();
      check("dual load started", 32'(rom_addr), 32'({3'd3, 7'd0}));
      wait_load_done(n);
      check("dual clear pending", 32'(busy), 32'd1);
      wait_idle();
      model(3, 81, exp_b, exp_bl, nz);
      check_wide("p3 board", board, exp_b);
      check("p3 blank", 32'(board_blank == exp_bl), 32'd1);
      check("p3 filled", 32'(filled), 32'(nz));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
